// File: rtl/heater_sequencer_if.sv
// Command channel into heater_sequencer: op, target code and hysteresis band.
// Latency: none, wires only.
// Backpressure: cmd_ready from the slave; a transfer happens when cmd_valid & cmd_ready.
interface heater_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_target;
    logic [7:0]  cmd_band;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_target,
        output cmd_band,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_target,
        input  cmd_band,
        output cmd_ready
    );
endinterface

// File: rtl/heater_sequencer.sv
// Command-driven heat/settle/hold sequencer in front of one heater_control instance.
// Latency: an accepted command or a state change shows on the registered outputs one cycle later.
// Backpressure: none, cmd_ready is always high and every command is consumed on the cycle it is valid.
// Build option HEATER_SEQ_WATCHDOG_EN adds the warm-up timeout and thermal-runaway faults.
// Temperature is an ADC code: a smaller code means hotter.
module heater_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int SETTLE_MS = 2000
`ifdef HEATER_SEQ_WATCHDOG_EN
    ,
    parameter int HEAT_TIMEOUT_MS = 300000,
    parameter int RUNAWAY_CODES   = 40,
    parameter int RUNAWAY_MS      = 5000
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    heater_sequencer_if.slave        cmd,
    input  logic [11:0]              temp,
    output logic [1:0]               heater_ctrl,
    output logic [11:0]              temp_upper,
    output logic [11:0]              temp_bottom,
    output logic                     busy,
    output logic                     ready,
    output logic                     done,
    output logic                     fault,
    output logic [1:0]               fault_code
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HEAT_ONCE = 3'd1,
        HEAT      = 3'd2,
        SETTLE    = 3'd3,
        HOLD      = 3'd4,
        FAULT     = 3'd5
    } state_e;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SETTLE_MS + 1);

    state_e         state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
    logic [3:0]     sensor_cnt_q, sensor_cnt_d;
    logic [1:0]     heater_ctrl_q, heater_ctrl_d;
    logic [11:0]    temp_upper_q, temp_upper_d;
    logic [11:0]    temp_bottom_q, temp_bottom_d;
    logic           busy_q, busy_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           fault_q, fault_d;
    logic [1:0]     fault_code_q, fault_code_d;

    logic           tick;
    logic           active;
    logic           sensor_bad;
    logic [12:0]    bottom_sum;

    // The sequencer never stalls the command channel.
    assign cmd.cmd_ready = 1'b1;

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign active     = (state_q != IDLE) && (state_q != FAULT);
    assign sensor_bad = (temp == 12'h000) || (temp == 12'hFFF);
    // 13-bit sum so the cold limit saturates instead of wrapping to a hot code.
    assign bottom_sum = {1'b0, cmd.cmd_target} + {5'd0, cmd.cmd_band};

`ifdef HEATER_SEQ_WATCHDOG_EN
    localparam int MW = $clog2(HEAT_TIMEOUT_MS + 1);
    localparam int RW = $clog2(RUNAWAY_MS + 1);

    logic [MW-1:0]  ms_cnt_q, ms_cnt_d;
    logic [RW-1:0]  runaway_cnt_q, runaway_cnt_d;
    logic           runaway_hot;

    // Colder than the band's cold edge by more than the tolerated margin.
    assign runaway_hot = {1'b0, temp} > ({1'b0, temp_bottom_q} + 13'(RUNAWAY_CODES));
`endif

    // Next state, counters and the values the output registers take next cycle.
    always_comb begin
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        temp_upper_d  = temp_upper_q;
        temp_bottom_d = temp_bottom_q;
        done_d        = 1'b0;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        settle_cnt_d  = '0;
        sensor_cnt_d  = '0;
`ifdef HEATER_SEQ_WATCHDOG_EN
        ms_cnt_d      = '0;
        runaway_cnt_d = '0;
`endif

        case (state_q)
            HEAT_ONCE: begin
                if (temp <= temp_upper_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            HEAT: begin
                if (temp <= temp_upper_q) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Any excursion above the cold edge restarts the settle window.
                if (temp <= temp_bottom_q) begin
                    settle_cnt_d = settle_cnt_q;
                    if (tick) begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                        if (settle_cnt_q == SW'(SETTLE_MS - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            default: ;
        endcase

`ifdef HEATER_SEQ_WATCHDOG_EN
        if ((state_q == HEAT_ONCE) || (state_q == HEAT)) begin
            ms_cnt_d = ms_cnt_q;
            if (tick) begin
                ms_cnt_d = ms_cnt_q + 1'b1;
                if (ms_cnt_q == MW'(HEAT_TIMEOUT_MS - 1)) begin
                    state_d      = FAULT;
                    fault_code_d = 2'b01;
                    done_d       = 1'b0;
                end
            end
        end
        if ((state_q == HOLD) && runaway_hot) begin
            runaway_cnt_d = runaway_cnt_q;
            if (tick) begin
                runaway_cnt_d = runaway_cnt_q + 1'b1;
                if (runaway_cnt_q == RW'(RUNAWAY_MS - 1)) begin
                    state_d      = FAULT;
                    fault_code_d = 2'b10;
                end
            end
        end
`endif

        // Stuck-at-rail sensor outranks the watchdog faults.
        if (active && sensor_bad) begin
            sensor_cnt_d = sensor_cnt_q + 1'b1;
            if (sensor_cnt_q == 4'd15) begin
                state_d      = FAULT;
                fault_code_d = 2'b11;
                done_d       = 1'b0;
            end
        end

        // An accepted command overrides whatever the state machine decided above.
        if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
                2'b00: begin
                    state_d      = IDLE;
                    fault_code_d = 2'b00;
                    done_d       = 1'b0;
                    settle_cnt_d = '0;
                    sensor_cnt_d = '0;
`ifdef HEATER_SEQ_WATCHDOG_EN
                    ms_cnt_d      = '0;
                    runaway_cnt_d = '0;
`endif
                end
                2'b01, 2'b10: begin
                    if (state_q != FAULT) begin
                        state_d       = (cmd.cmd_op == 2'b01) ? HEAT_ONCE : HEAT;
                        fault_code_d  = 2'b00;
                        done_d        = 1'b0;
                        temp_upper_d  = cmd.cmd_target;
                        temp_bottom_d = bottom_sum[12] ? 12'hFFF : bottom_sum[11:0];
                        settle_cnt_d  = '0;
`ifdef HEATER_SEQ_WATCHDOG_EN
                        ms_cnt_d      = '0;
                        runaway_cnt_d = '0;
`endif
                    end
                end
                default: ;
            endcase
        end

        heater_ctrl_d = 2'b00;
        case (state_d)
            HEAT_ONCE, HEAT: heater_ctrl_d = 2'b01;
            SETTLE, HOLD:    heater_ctrl_d = 2'b10;
            default:         heater_ctrl_d = 2'b00;
        endcase
        busy_d  = (state_d != IDLE) && (state_d != FAULT);
        ready_d = (state_d == HOLD);
        fault_d = (state_d == FAULT);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            sensor_cnt_q  <= '0;
            heater_ctrl_q <= 2'b00;
            temp_upper_q  <= '0;
            temp_bottom_q <= '0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= 2'b00;
`ifdef HEATER_SEQ_WATCHDOG_EN
            ms_cnt_q      <= '0;
            runaway_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            sensor_cnt_q  <= sensor_cnt_d;
            heater_ctrl_q <= heater_ctrl_d;
            temp_upper_q  <= temp_upper_d;
            temp_bottom_q <= temp_bottom_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
`ifdef HEATER_SEQ_WATCHDOG_EN
            ms_cnt_q      <= ms_cnt_d;
            runaway_cnt_q <= runaway_cnt_d;
`endif
        end
    end

    assign heater_ctrl = heater_ctrl_q;
    assign temp_upper  = temp_upper_q;
    assign temp_bottom = temp_bottom_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_heater_sequencer.sv
// Directed bench for heater_sequencer with a 4-cycle ms tick.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: cmd_ready is expected high throughout; commands are one-cycle pulses.
module tb_heater_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] temp;
    logic [1:0]  heater_ctrl;
    logic [11:0] temp_upper;
    logic [11:0] temp_bottom;
    logic        busy;
    logic        ready;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    int vec_cnt = 0;
    int err_cnt = 0;

    heater_sequencer_if cmd_if ();

    always #5 clk = ~clk;

    heater_sequencer #(
        .TICK_DIV  (4),
        .SETTLE_MS (5)
`ifdef HEATER_SEQ_WATCHDOG_EN
        ,
        .HEAT_TIMEOUT_MS (50),
        .RUNAWAY_CODES   (10),
        .RUNAWAY_MS      (3)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd_if),
        .temp        (temp),
        .heater_ctrl (heater_ctrl),
        .temp_upper  (temp_upper),
        .temp_bottom (temp_bottom),
        .busy        (busy),
        .ready       (ready),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle command; returns at the falling edge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [11:0] tgt, input logic [7:0] band);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_op     = op;
        cmd_if.cmd_target = tgt;
        cmd_if.cmd_band   = band;
        cyc(1);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic go_hold();
        temp = 12'd1000;
        send(2'b10, 12'd1000, 8'd20);
        for (int i = 0; i < 30 && !ready; i++) cyc(1);
        chk("hold_entry", ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctrl"},  heater_ctrl, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_code"},  fault_code, 0);
        chk({tag, "_upper"}, temp_upper, 0);
        chk({tag, "_bot"},   temp_bottom, 0);
        chk({tag, "_crdy"},  cmd_if.cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst               = 1'b1;
        temp              = 12'd2000;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = 2'b00;
        cmd_if.cmd_target = '0;
        cmd_if.cmd_band   = '0;
        cyc(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        cyc(1);

        // 1: heat-and-hold, ramp down into the band, settle to HOLD
        send(2'b10, 12'd1000, 8'd20);
        chk("s1_ctrl_heat", heater_ctrl, 1);
        chk("s1_upper", temp_upper, 1000);
        chk("s1_bottom", temp_bottom, 1020);
        chk("s1_busy", busy, 1);
        for (int t = 1900; t >= 1100; t -= 100) begin
            temp = 12'(t);
            cyc(1);
        end
        chk("s1_ramp_still_heat", heater_ctrl, 1);
        temp = 12'd1000;
        cyc(1);
        chk("s1_settle_ctrl", heater_ctrl, 2);
        temp = 12'd1010;
        cyc(16);
        chk("s1_not_ready_early", ready, 0);
        for (int i = 0; i < 4 && !ready; i++) cyc(1);
        chk("s1_ready", ready, 1);
        chk("s1_hold_ctrl", heater_ctrl, 2);

        // 4: runaway in HOLD, 3 ticks beyond the limit
        temp = 12'd1031;
        cyc(12);
`ifdef HEATER_SEQ_WATCHDOG_EN
        chk("s4_runaway_fault", fault, 1);
        chk("s4_runaway_code", fault_code, 2);
        chk("s4_runaway_ctrl", heater_ctrl, 0);
        chk("s4_runaway_ready", ready, 0);
`else
        chk("s4_nowd_fault", fault, 0);
        chk("s4_nowd_ready", ready, 1);
        chk("s4_nowd_ctrl", heater_ctrl, 2);
`endif
        send(2'b00, 12'd0, 8'd0);
        chk("s4_off_ctrl", heater_ctrl, 0);
        chk("s4_off_code", fault_code, 0);
        go_hold();
        temp = 12'd1031;
        cyc(8);
        temp = 12'd1000;
        cyc(12);
        chk("s4_short_no_fault", fault, 0);
        chk("s4_short_ready", ready, 1);

        // 2: heat-once completes with a single done pulse
        temp = 12'd1800;
        send(2'b00, 12'd0, 8'd0);
        send(2'b01, 12'd1500, 8'd20);
        chk("s2_ctrl_heat", heater_ctrl, 1);
        temp = 12'd1700;
        cyc(1);
        temp = 12'd1600;
        cyc(1);
        chk("s2_done_low", done, 0);
        temp = 12'd1500;
        cyc(1);
        chk("s2_done_pulse", done, 1);
        chk("s2_idle_ctrl", heater_ctrl, 0);
        chk("s2_idle_busy", busy, 0);
        cyc(1);
        chk("s2_done_once", done, 0);

        // 3: warm-up timeout with temperature stuck cold
        temp = 12'd3000;
        send(2'b10, 12'd1000, 8'd20);
        cyc(196);
        chk("s3_no_fault_49", fault, 0);
        cyc(4);
`ifdef HEATER_SEQ_WATCHDOG_EN
        chk("s3_timeout_fault", fault, 1);
        chk("s3_timeout_code", fault_code, 1);
        chk("s3_timeout_ctrl", heater_ctrl, 0);
        send(2'b01, 12'd1000, 8'd20);
        chk("s3_op01_ignored", fault, 1);
        chk("s3_op01_ctrl", heater_ctrl, 0);
`else
        chk("s3_nowd_fault", fault, 0);
        chk("s3_nowd_ctrl", heater_ctrl, 1);
        chk("s3_nowd_busy", busy, 1);
        send(2'b01, 12'd1000, 8'd20);
        chk("s3_nowd_op01_ctrl", heater_ctrl, 1);
`endif
        send(2'b00, 12'd0, 8'd0);
        chk("s3_clear_fault", fault, 0);
        chk("s3_clear_code", fault_code, 0);
        chk("s3_clear_busy", busy, 0);

        // 5: reserved op ignored, then stuck-at-rail sensor during HEAT
        temp = 12'd2000;
        send(2'b10, 12'd1000, 8'd20);
        send(2'b11, 12'd500, 8'd5);
        chk("s5_op11_ctrl", heater_ctrl, 1);
        chk("s5_op11_upper", temp_upper, 1000);
        temp = 12'hFFF;
        cyc(15);
        temp = 12'd2000;
        cyc(2);
        chk("s5_15_no_fault", fault, 0);
        chk("s5_15_ctrl", heater_ctrl, 1);
        temp = 12'hFFF;
        cyc(16);
        chk("s5_16_fault", fault, 1);
        chk("s5_16_code", fault_code, 3);
        chk("s5_16_ctrl", heater_ctrl, 0);
        temp = 12'd2000;
        send(2'b00, 12'd0, 8'd0);
        chk("s5_clear_code", fault_code, 0);

        // Cold limit saturates at the top code
        send(2'b10, 12'hFF0, 8'h20);
        chk("sat_bottom", temp_bottom, 12'hFFF);
        chk("sat_upper", temp_upper, 12'hFF0);
        send(2'b00, 12'd0, 8'd0);

        // 6: reset in the middle of SETTLE
        temp = 12'd1000;
        send(2'b10, 12'd1000, 8'd20);
        cyc(1);
        chk("s6_settle_ctrl", heater_ctrl, 2);
        rst = 1'b1;
        cyc(1);
        chk_reset_outputs("s6_rst");
        rst = 1'b0;
        cyc(1);
        chk("s6_after_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
